// File: rtl/pulse_transmitter_job_scheduler.sv
// Job scheduler for the pulse transmitter: queues job descriptors and launches them one at a time,
// with a programmable idle gap between jobs and an abort that flushes everything.
module pulse_transmitter_job_scheduler #(
    parameter int DEPTH = 4,
    parameter int GAP_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     job_valid,
    output logic                     job_ready,
    input  logic [6:0]               job_start_index,
    input  logic [6:0]               job_end_index,
    input  logic [7:0]               job_loop_count,
    input  logic [6:0]               job_loopback_idx,
    input  logic [3:0]               job_id,
    input  logic                     enable,
    input  logic                     abort,
    input  logic [GAP_W-1:0]         gap_cycles,
    output logic [6:0]               tx_start_index,
    output logic [6:0]               tx_end_index,
    output logic [7:0]               tx_loop_count,
    output logic [6:0]               tx_loopback_idx,
    output logic                     tx_run,
    input  logic                     tx_done,
    output logic                     job_done,
    output logic                     job_aborted,
    output logic [3:0]               done_id,
    output logic [$clog2(DEPTH):0]   queue_count,
    output logic                     busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int JOB_W = 33;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_d;
    logic [JOB_W-1:0] mem [DEPTH];
    logic [JOB_W-1:0] head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [GAP_W-1:0] gap_cnt;
    logic [GAP_W-1:0] gap_load;
    logic [3:0]       cur_id;
    logic             full;
    logic             push;
    logic             pop;
    logic             avail;
    logic             gap_start;

    // Handshake: a job transfers on a clock edge where job_valid && job_ready and abort is low.
    assign full      = (count == CNT_W'(DEPTH));
    assign job_ready = rst_n && !full;
    assign push      = job_valid && !full && !abort;
    assign pop       = (state == S_LOAD) && !abort && (count != '0);
    // A job being pushed this cycle counts as available, so an idle block launches without an extra cycle.
    assign avail     = (count != '0) || push;
    assign gap_load  = (gap_cycles == '0) ? GAP_W'(1) : gap_cycles;
    assign gap_start = (abort && (state != S_IDLE)) || (!abort && (state == S_RUN) && tx_done);
    assign head      = mem[rd_ptr];

    assign tx_run      = (state == S_RUN);
    assign busy        = (state != S_IDLE);
    assign queue_count = count;

    always_comb begin
        state_d = state;
        if (abort) begin
            state_d = (state == S_IDLE) ? S_IDLE : S_GAP;
        end else begin
            case (state)
                S_IDLE: if (enable && avail) state_d = S_LOAD;
                S_LOAD: state_d = S_RUN;
                S_RUN:  if (tx_done) state_d = S_GAP;
                S_GAP: begin
                    if (gap_cnt <= GAP_W'(1)) begin
                        state_d = (enable && avail) ? S_LOAD : S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {job_start_index, job_end_index, job_loop_count, job_loopback_idx, job_id};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            gap_cnt         <= '0;
            cur_id          <= '0;
            tx_start_index  <= '0;
            tx_end_index    <= '0;
            tx_loop_count   <= '0;
            tx_loopback_idx <= '0;
            job_done        <= 1'b0;
            job_aborted     <= 1'b0;
            done_id         <= '0;
        end else begin
            state <= state_d;

            if (abort) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end

            if (pop) begin
                tx_start_index  <= head[32:26];
                tx_end_index    <= head[25:19];
                tx_loop_count   <= head[18:11];
                tx_loopback_idx <= head[10:4];
                cur_id          <= head[3:0];
            end

            if (gap_start) begin
                gap_cnt <= gap_load;
            end else if (state == S_GAP) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end

            job_done    <= !abort && (state == S_RUN) && tx_done;
            job_aborted <= abort && (state == S_RUN);
            if (state == S_RUN && (abort || tx_done)) begin
                done_id <= cur_id;
            end
        end
    end

endmodule

// File: tb/tb_pulse_transmitter_job_scheduler.sv
// Bench for pulse_transmitter_job_scheduler: a queue of accepted jobs is the reference model; a monitor
// checks every launch, completion, abort and the FIFO occupancy against it.
module tb_pulse_transmitter_job_scheduler;

    localparam int DEPTH = 4;
    localparam int GAP_W = 16;
    localparam int W     = 33;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              job_valid = 1'b0;
    logic              job_ready;
    logic [6:0]        job_start_index = '0;
    logic [6:0]        job_end_index = '0;
    logic [7:0]        job_loop_count = '0;
    logic [6:0]        job_loopback_idx = '0;
    logic [3:0]        job_id = '0;
    logic              enable = 1'b0;
    logic              abort = 1'b0;
    logic [GAP_W-1:0]  gap_cycles = '0;
    logic [6:0]        tx_start_index;
    logic [6:0]        tx_end_index;
    logic [7:0]        tx_loop_count;
    logic [6:0]        tx_loopback_idx;
    logic              tx_run;
    logic              tx_done;
    logic              job_done;
    logic              job_aborted;
    logic [3:0]        done_id;
    logic [2:0]        queue_count;
    logic              busy;

    logic auto_done = 1'b0;
    logic man_done  = 1'b0;
    assign tx_done = auto_done | man_done;

    always #5 clk = ~clk;

    pulse_transmitter_job_scheduler #(.DEPTH(DEPTH), .GAP_W(GAP_W)) dut (
        .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_ready(job_ready),
        .job_start_index(job_start_index), .job_end_index(job_end_index),
        .job_loop_count(job_loop_count), .job_loopback_idx(job_loopback_idx), .job_id(job_id),
        .enable(enable), .abort(abort), .gap_cycles(gap_cycles),
        .tx_start_index(tx_start_index), .tx_end_index(tx_end_index),
        .tx_loop_count(tx_loop_count), .tx_loopback_idx(tx_loopback_idx),
        .tx_run(tx_run), .tx_done(tx_done), .job_done(job_done), .job_aborted(job_aborted),
        .done_id(done_id), .queue_count(queue_count), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: jobs accepted and not yet launched, in order.
    logic [W-1:0] exp_q[$];
    logic [3:0]   done_log[$];
    logic [W-1:0] cur_job = '0;
    logic         run_flag = 1'b0;
    int           launch_cnt = 0;
    int           low_cnt = 0;
    bit           have_fall = 0;
    bit           gap_chk_en = 0;
    int           gap_exp = 0;
    bit           mon_en = 1;
    bit           auto_tx = 1;
    int           lat_lo = 20;
    int           lat_hi = 20;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_job(input logic [3:0] id);
        logic [6:0] s;
        logic [6:0] e;
        logic [7:0] l;
        logic [6:0] b;
        s = 7'($urandom);
        e = 7'($urandom);
        l = 8'($urandom);
        b = 7'($urandom);
        return {s, e, l, b, id};
    endfunction

    // Inputs change on the falling edge; the model is updated at the rising edge that samples them.
    task automatic drive_cycle(input logic v, input logic [W-1:0] job, input logic ab, input logic md);
        @(negedge clk);
        job_valid = v;
        {job_start_index, job_end_index, job_loop_count, job_loopback_idx, job_id} = job;
        abort = ab;
        man_done = md;
        if (mon_en && rst_n) check("job_ready", job_ready, exp_q.size() < DEPTH);
        @(posedge clk);
        if (ab) exp_q.delete();
        else if (v && exp_q.size() < DEPTH) exp_q.push_back(job);
    endtask

    task automatic idle();
        drive_cycle(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic set_ctl(input logic en, input logic [GAP_W-1:0] gap);
        @(negedge clk);
        enable = en;
        gap_cycles = gap;
    endtask

    task automatic wait_launch(input int target);
        int n = 0;
        while (launch_cnt < target && n < 400) begin
            idle();
            #2;
            n++;
        end
        if (launch_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL wait_launch actual=%0d required=%0d", launch_cnt, target);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 3000) begin
            idle();
            #2;
            n++;
        end
        check("wait_idle_busy", busy, 1'b0);
    endtask

    // Transmitter stand-in: tx_done arrives a chosen number of cycles after the run rise.
    int tcnt = 0;
    int tlat = 1;
    initial begin
        forever begin
            @(negedge clk);
            auto_done = 1'b0;
            if (tx_run && rst_n) begin
                if (tcnt == 0) tlat = $urandom_range(lat_hi, lat_lo);
                tcnt++;
                if (auto_tx && tcnt == tlat + 1) auto_done = 1'b1;
            end else begin
                tcnt = 0;
            end
        end
    end

    // Monitor / scoreboard
    logic td_s;
    logic ab_s;
    logic wr_s;
    logic exp_done;
    logic exp_ab;
    initial begin
        forever begin
            @(posedge clk);
            td_s = tx_done;
            ab_s = abort;
            wr_s = run_flag;
            #1;
            if (!mon_en || !rst_n) begin
                run_flag = 1'b0;
                have_fall = 0;
                continue;
            end
            exp_done = td_s && wr_s && !ab_s;
            exp_ab   = ab_s && wr_s;
            check("job_done", job_done, exp_done);
            check("job_aborted", job_aborted, exp_ab);
            if (exp_done || exp_ab) check("done_id", done_id, cur_job[3:0]);
            if (exp_done) done_log.push_back(cur_job[3:0]);
            if (tx_run && !wr_s) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL launch_without_job actual=launch required=none");
                end else begin
                    cur_job = exp_q.pop_front();
                    check("tx_cfg", {tx_start_index, tx_end_index, tx_loop_count, tx_loopback_idx},
                          cur_job[32:4]);
                end
                launch_cnt++;
                if (gap_chk_en && have_fall) check("gap_low_cycles", low_cnt, gap_exp);
            end else if (tx_run) begin
                check("tx_cfg_stable", {tx_start_index, tx_end_index, tx_loop_count, tx_loopback_idx},
                      cur_job[32:4]);
            end
            if (!tx_run) begin
                low_cnt = wr_s ? 1 : low_cnt + 1;
                if (wr_s) have_fall = 1;
            end
            check("queue_count", queue_count, exp_q.size());
            run_flag = tx_run;
        end
    end

    initial begin
        int l0;
        int l1;
        int n;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_run", tx_run, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_queue_count", queue_count, 3'd0);
        check("rst_job_ready", job_ready, 1'b0);
        check("rst_job_done", job_done, 1'b0);
        check("rst_job_aborted", job_aborted, 1'b0);
        check("rst_done_id", done_id, 4'd0);
        check("rst_tx_cfg", {tx_start_index, tx_end_index, tx_loop_count, tx_loopback_idx}, 29'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", job_ready, 1'b1);

        // Three jobs back to back, gap 5, transmitter done 20 cycles after each launch
        lat_lo = 20; lat_hi = 20;
        set_ctl(1'b1, 16'd5);
        gap_chk_en = 1; gap_exp = 6;
        drive_cycle(1'b1, rand_job(4'd1), 1'b0, 1'b0);
        drive_cycle(1'b1, rand_job(4'd2), 1'b0, 1'b0);
        #1;
        check("launch_latency", tx_run, 1'b1);
        drive_cycle(1'b1, rand_job(4'd3), 1'b0, 1'b0);
        n = 0;
        while (done_log.size() < 3 && n < 400) begin
            idle();
            #2;
            n++;
        end
        check("done_count", done_log.size(), 3);
        for (int i = 0; i < done_log.size() && i < 3; i++) check("done_order", done_log[i], i + 1);
        wait_idle();
        gap_chk_en = 0;
        done_log.delete();

        // Fill the FIFO with enable low; the fifth push is dropped
        lat_lo = 3; lat_hi = 3;
        set_ctl(1'b0, 16'd2);
        l0 = launch_cnt;
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, rand_job(4'(8 + i)), 1'b0, 1'b0);
        #1;
        check("fill_queue_count", queue_count, 3'd4);
        check("fill_job_ready", job_ready, 1'b0);
        set_ctl(1'b1, 16'd2);
        wait_idle();
        check("fill_launches", launch_cnt - l0, 4);

        // Full FIFO: push during the LOAD pop is refused, a later push is accepted
        set_ctl(1'b0, 16'd3);
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, rand_job(4'(i)), 1'b0, 1'b0);
        set_ctl(1'b1, 16'd3);
        drive_cycle(1'b1, rand_job(4'd14), 1'b0, 1'b0);
        #1;
        check("full_pop_count", queue_count, 3'd3);
        drive_cycle(1'b1, rand_job(4'd15), 1'b0, 1'b0);
        #1;
        check("refill_count", queue_count, 3'd4);
        wait_idle();

        // Abort during RUN of id 7 with two jobs queued
        lat_lo = 30; lat_hi = 30;
        set_ctl(1'b1, 16'd4);
        l0 = launch_cnt;
        drive_cycle(1'b1, rand_job(4'd7), 1'b0, 1'b0);
        drive_cycle(1'b1, rand_job(4'd5), 1'b0, 1'b0);
        drive_cycle(1'b1, rand_job(4'd6), 1'b0, 1'b0);
        wait_launch(l0 + 1);
        repeat (5) idle();
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
        #1;
        check("abort_pulse", job_aborted, 1'b1);
        check("abort_id", done_id, 4'd7);
        check("abort_tx_run", tx_run, 1'b0);
        check("abort_queue", queue_count, 3'd0);
        l1 = launch_cnt;
        n = 0;
        while (busy && n < 50) begin
            idle();
            #1;
            n++;
        end
        check("abort_gap_len", n, 4);
        repeat (10) idle();
        check("abort_no_launch", launch_cnt, l1);

        // gap 0 behaves as 1; abort beats a simultaneous tx_done; stray tx_done ignored
        auto_tx = 0;
        set_ctl(1'b1, 16'd0);
        l0 = launch_cnt;
        drive_cycle(1'b1, rand_job(4'd9), 1'b0, 1'b0);
        drive_cycle(1'b1, rand_job(4'd10), 1'b0, 1'b0);
        wait_launch(l0 + 1);
        repeat (2) idle();
        gap_chk_en = 1; gap_exp = 2;
        drive_cycle(1'b0, '0, 1'b0, 1'b1);
        #1;
        check("gap0_job_done", job_done, 1'b1);
        wait_launch(l0 + 2);
        gap_chk_en = 0;
        repeat (2) idle();
        drive_cycle(1'b0, '0, 1'b1, 1'b1);
        #1;
        check("abort_wins_done", job_done, 1'b0);
        check("abort_wins_aborted", job_aborted, 1'b1);
        check("abort_wins_id", done_id, 4'd10);
        idle();
        #1;
        check("gap0_idle", busy, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, '0, 1'b0, 1'b1);
            #1;
            check("stray_done", job_done, 1'b0);
            check("stray_busy", busy, 1'b0);
        end
        auto_tx = 1;

        // Randomised traffic
        lat_lo = 1; lat_hi = 8;
        for (int i = 0; i < 400; i++) begin
            if (i % 40 == 0) set_ctl($urandom_range(0, 3) != 0, 16'($urandom_range(0, 3)));
            drive_cycle($urandom_range(0, 2) == 0, rand_job(4'($urandom)),
                        $urandom_range(0, 79) == 0, 1'b0);
        end
        set_ctl(1'b1, 16'd1);
        wait_idle();

        // Asynchronous reset in the middle of a run
        lat_lo = 50; lat_hi = 50;
        set_ctl(1'b1, 16'd2);
        l0 = launch_cnt;
        drive_cycle(1'b1, rand_job(4'd3), 1'b0, 1'b0);
        drive_cycle(1'b1, rand_job(4'd4), 1'b0, 1'b0);
        wait_launch(l0 + 1);
        repeat (3) idle();
        @(posedge clk);
        #3;
        mon_en = 0;
        rst_n = 1'b0;
        #1;
        check("arst_tx_run", tx_run, 1'b0);
        check("arst_queue", queue_count, 3'd0);
        check("arst_busy", busy, 1'b0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1;
        idle();
        #1;
        check("post_reset_busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
